// File: rtl/ks10_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package ks10_fetch_pkg;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 36;
  localparam int unsigned EW = DW + AW;

  localparam logic [AW-1:0] PC_MAX = 18'o777777;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ERROR
  } fetch_state_e;

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
    return (pc == PC_MAX) ? '0 : pc + 1'b1;
  endfunction

endpackage

// File: rtl/ir_prefetch_fifo.sv
// Prefetch queue of {word, pc} entries; flush has priority over push/pop.
module ir_prefetch_fifo
  import ks10_fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [EW-1:0]             din_i,
  output logic [EW-1:0]             dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(QDEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

  logic [EW-1:0] mem_q [QDEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  // A push while full is only legal alongside a pop.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (!flush_i && push_ok) mem_q[wptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ir_fetch_ctl.sv
// Instruction fetch sequencer: one outstanding memory read, prefetch queue,
// IR load strobe, redirect, timeout and error handling.
module ir_fetch_ctl
  import ks10_fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned TMOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          pc_load,
  input  logic [17:0]   pc_in,
  output logic          mem_req,
  output logic [17:0]   mem_addr,
  input  logic          mem_ack,
  input  logic          mem_err,
  input  logic [0:35]   mem_data,
  input  logic          dec_rdy,
  output logic          ir_clken,
  output logic [0:35]   ir_dbus,
  output logic [17:0]   ir_pc,
  output logic          q_valid,
  output logic          fetch_err,
  output logic [17:0]   err_addr
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned TW = $clog2(TMOUT + 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(QDEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMOUT - 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic [EW-1:0] head;
  logic          q_full, q_empty;
  logic [PW:0]   q_count, cnt_after;
  logic          ack_ok, push, pop, full_after;

  assign mem_req  = (state_q == REQ);
  assign mem_addr = pc_q;

  // Redirect wins over a same-cycle ack and suppresses the IR load.
  assign ack_ok   = mem_ack & mem_req & ~pc_load;
  assign push     = ack_ok & ~mem_err;
  assign pop      = dec_rdy & ~q_empty & ~pc_load;

  assign cnt_after  = q_count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign full_after = (cnt_after == FULL_CNT);

  assign ir_clken  = pop;
  assign q_valid   = ~q_empty;
  assign ir_dbus   = q_empty ? '0 : head[EW-1:AW];
  assign ir_pc     = q_empty ? '0 : head[AW-1:0];
  assign fetch_err = err_q;
  assign err_addr  = err_addr_q;

  ir_prefetch_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (pc_load),
    .din_i   ({mem_data, pc_q}),
    .dout_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    tmo_d      = '0;
    if (pc_load) begin
      pc_d    = pc_in;
      err_d   = 1'b0;
      state_d = (state_q == ERROR || !run) ? IDLE : REQ;
    end else begin
      case (state_q)
        IDLE: if (run && !q_full) state_d = REQ;
        REQ: begin
          if (ack_ok) begin
            if (mem_err) begin
              err_d      = 1'b1;
              err_addr_d = pc_q;
              state_d    = ERROR;
            end else begin
              pc_d    = pc_inc(pc_q);
              state_d = (run && !full_after) ? REQ : IDLE;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_d      = 1'b1;
            err_addr_d = pc_q;
            state_d    = ERROR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_ir_fetch_ctl.sv
// Scoreboard bench for ir_fetch_ctl with a transaction-level fetch model.
module tb_ir_fetch_ctl;
  import ks10_fetch_pkg::*;

  localparam int unsigned QDEPTH = 2;
  localparam int unsigned TMOUT  = 255;

  logic        clk, rst, run, pc_load, mem_ack, mem_err, dec_rdy;
  logic [17:0] pc_in, mem_addr, ir_pc, err_addr;
  logic [0:35] mem_data, ir_dbus;
  logic        mem_req, ir_clken, q_valid, fetch_err;

  ir_fetch_ctl #(.QDEPTH(QDEPTH), .TMOUT(TMOUT)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_load(pc_load), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_err(mem_err), .mem_data(mem_data), .dec_rdy(dec_rdy),
    .ir_clken(ir_clken), .ir_dbus(ir_dbus), .ir_pc(ir_pc),
    .q_valid(q_valid), .fetch_err(fetch_err), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_pct = 100;
  int err_pct = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] mem_word(input logic [17:0] a);
    logic [17:0] t;
    t = a * 18'd3 + 18'o1234;
    return {a ^ 18'o525252, t};
  endfunction

  // Reference model: queue of words the memory handed over, fetch PC, error.
  logic [53:0] expq[$];
  logic [17:0] m_pc, m_ea;
  bit          m_err;
  int          m_tcnt;
  logic [53:0] hd;
  bit          exp_ld;

  always @(negedge clk) begin
    if (!rst) begin
      expq.delete();
      m_pc = '0; m_err = 0; m_ea = '0; m_tcnt = 0;
    end else begin
      exp_ld = dec_rdy && (expq.size() != 0) && !pc_load;
      chk("q_valid", q_valid, expq.size() != 0);
      chk("ir_clken", ir_clken, exp_ld);
      if (expq.size() != 0) begin
        hd = expq[0];
        chk("ir_dbus", ir_dbus, hd[53:18]);
        chk("ir_pc", ir_pc, hd[17:0]);
      end else begin
        chk("ir_dbus_empty", ir_dbus, 36'd0);
        chk("ir_pc_empty", ir_pc, 18'd0);
      end
      chk("fetch_err", fetch_err, m_err);
      if (m_err) begin
        chk("err_addr", err_addr, m_ea);
        chk("req_in_error", mem_req, 1'b0);
      end
      if (mem_req) begin
        chk("mem_addr", mem_addr, m_pc);
        chk("req_with_room", expq.size() < QDEPTH, 1'b1);
      end
      if (pc_load) begin
        expq.delete();
        m_pc = pc_in; m_err = 0; m_tcnt = 0;
      end else begin
        if (ir_clken && expq.size() != 0) void'(expq.pop_front());
        if (mem_req && mem_ack) begin
          m_tcnt = 0;
          if (mem_err) begin
            m_err = 1; m_ea = m_pc;
          end else begin
            expq.push_back({mem_word(m_pc), m_pc});
            m_pc = 18'((int'(m_pc) + 1) % (1 << 18));
          end
        end else if (mem_req) begin
          m_tcnt++;
          if (m_tcnt == TMOUT) begin
            m_err = 1; m_ea = m_pc; m_tcnt = 0;
          end
        end else begin
          m_tcnt = 0;
        end
      end
    end
  end

  // One clock of stimulus; memory answers only an asserted request.
  task automatic cyc();
    @(posedge clk);
    #1;
    pc_load  = 1'b0;
    mem_ack  = mem_req && ($urandom_range(99) < ack_pct);
    mem_err  = mem_ack && ($urandom_range(99) < err_pct);
    mem_data = mem_ack ? mem_word(mem_addr) : '0;
  endtask

  task automatic do_load(input logic [17:0] a);
    cyc();
    pc_load = 1'b1;
    pc_in   = a;
  endtask

  task automatic wait_req(input string nm, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      cyc();
      if (mem_req) begin ok = 1; break; end
    end
    chk(nm, ok, 1'b1);
  endtask

  bit ok, found;

  initial begin
    rst = 1'b0; run = 1'b0; pc_load = 1'b0; pc_in = '0; dec_rdy = 1'b0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 18'd0);
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_fetch_err", fetch_err, 1'b0);
    chk("rst_err_addr", err_addr, 18'd0);
    rst = 1'b1;

    // Reset while a request is outstanding.
    run = 1'b1; dec_rdy = 1'b1; ack_pct = 0;
    wait_req("first_req", 10, ok);
    #3 rst = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_q_valid", q_valid, 1'b0);
    chk("midrst_ir_clken", ir_clken, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    wait_req("req_after_rst", 10, ok);
    chk("addr_after_rst", mem_addr, 18'd0);

    // Straight-line fetch from 1000.
    ack_pct = 100;
    do_load(18'o1000);
    repeat (12) cyc();

    // Fill the queue with decode stalled.
    dec_rdy = 1'b0;
    do_load(18'o1100);
    repeat (8) cyc();
    chk("full_mem_req", mem_req, 1'b0);
    chk("full_q_valid", q_valid, 1'b1);
    cyc(); dec_rdy = 1'b1;
    cyc(); dec_rdy = 1'b0;
    wait_req("refill_after_pop", 4, ok);
    repeat (3) cyc();

    // Redirect in the same cycle as an ack.
    dec_rdy = 1'b1; ack_pct = 0;
    do_load(18'o1003);
    wait_req("req_1003", 10, ok);
    mem_ack = 1'b1; mem_err = 1'b0; mem_data = mem_word(mem_addr);
    pc_load = 1'b1; pc_in = 18'o2000;
    ack_pct = 100;
    cyc();
    chk("redirect_q_empty", q_valid, 1'b0);
    repeat (5) cyc();

    // Error at the top of memory with a word still queued.
    dec_rdy = 1'b0;
    do_load(18'o777776);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (mem_req && mem_addr == PC_MAX) begin mem_err = 1'b1; found = 1; break; end
    end
    chk("reach_777777", found, 1'b1);
    cyc();
    chk("err_flag", fetch_err, 1'b1);
    chk("err_at_max", err_addr, PC_MAX);
    chk("err_q_valid", q_valid, 1'b1);
    dec_rdy = 1'b1;
    repeat (3) cyc();
    chk("err_drained", q_valid, 1'b0);
    chk("err_no_req", mem_req, 1'b0);

    // Wrap 777777 -> 0; the redirect also clears the error.
    do_load(PC_MAX);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (mem_req && mem_addr == 18'd0) begin found = 1; break; end
    end
    chk("wrap_to_0", found, 1'b1);
    chk("err_cleared", fetch_err, 1'b0);

    // Timeout with no ack.
    ack_pct = 0;
    do_load(18'o3000);
    repeat (TMOUT + 5) cyc();
    chk("tmo_err", fetch_err, 1'b1);
    chk("tmo_addr", err_addr, 18'o3000);
    do_load(18'o0);
    cyc();
    chk("tmo_cleared", fetch_err, 1'b0);

    // Randomized traffic.
    ack_pct = 40; err_pct = 3;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      run     = ($urandom_range(9) != 0);
      dec_rdy = ($urandom_range(99) < 60);
      if ($urandom_range(99) < 3) begin
        pc_load = 1'b1;
        pc_in   = ($urandom_range(3) == 0) ? PC_MAX - 18'($urandom_range(3))
                                           : 18'($urandom);
      end
    end
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_fetch_ctl.md
Name: ir_fetch_ctl

Overview:
- Instruction fetch sequencer feeding the Instruction Register.
- Issues 36-bit memory reads at the fetch PC and buffers returned words in a small prefetch queue.
- Presents the queue head to the IR load path with a one-cycle clock-enable pulse when decode accepts an instruction.
- Handles redirects (jumps/interrupts), memory timeouts and errors.

Parameters:
- QDEPTH, 2, prefetch queue entries (power of two, 2..8)
- TMOUT, 255, cycles from mem_req to mem_ack before a timeout (NXM) error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- run  in  1  fetch enable; 0 stops new requests
- pc_load  in  1  redirect strobe; load fetch PC, flush queue
- pc_in  in  18  redirect address
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  18  read address
- mem_ack  in  1  read complete, data valid this cycle
- mem_err  in  1  with mem_ack: page fail/parity error
- mem_data  in  36  read data [0:35]
- dec_rdy  in  1  decode accepts next instruction
- ir_clken  out  1  IR load enable pulse
- ir_dbus  out  36  word driven to IR input bus (queue head)
- ir_pc  out  18  address of word on ir_dbus
- q_valid  out  1  queue non-empty
- fetch_err  out  1  sticky error flag
- err_addr  out  18  address of failing fetch

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; fetch PC = 0; queue empty.
  - All outputs are 0: mem_req, mem_addr, ir_clken, ir_dbus, ir_pc, q_valid, fetch_err, err_addr.
- States:
  - IDLE: mem_req=0. Go to REQ when run=1 and queue not full.
  - REQ: mem_req=1, mem_addr = fetch PC; the address is held stable until ack.
    - mem_ack & !mem_err: push {mem_data, addr}; PC += 1, wrapping 18'o777777 -> 0. Go to REQ if run and queue not full after the push, otherwise IDLE.
    - mem_ack & mem_err: fetch_err=1, err_addr = addr, go to ERROR; the word is not pushed.
    - Timeout counter reaches TMOUT without ack: same as an error. The counter clears on every entry to REQ.
  - ERROR: mem_req=0. Queue still drains to decode. Leave ERROR only on pc_load, which also clears fetch_err, then go to IDLE.
- Handshake: exactly one outstanding request. mem_ack is ignored when mem_req=0.
- Delivery:
  - ir_dbus/ir_pc always show the queue head, 0 when empty.
  - ir_clken = dec_rdy & q_valid, combinational. Pop occurs on the same edge as the IR load.
  - Latency, empty queue, memory acking in the same cycle: word visible on ir_dbus 1 cycle after mem_ack edge; earliest IR load on the following edge.
- Simultaneous push and pop when full: allowed; occupancy is unchanged.
  - A push with occupancy==QDEPTH and no pop cannot occur, because no request is issued when full.
- pc_load (highest priority):
  - Queue flushed, PC = pc_in, ir_clken forced 0 that cycle.
  - If a request is outstanding, mem_req drops. The redirected request starts next cycle in REQ, or goes to IDLE if run=0.
  - A mem_ack in the same cycle as pc_load is discarded.
- run=0 while in REQ: the current request completes; no further request is issued.
- Occupancy counter is width clog2(QDEPTH)+1. Read/write pointers wrap modulo QDEPTH.

Decomposition:
- Shared package ks10_fetch_pkg:
  - state enum {IDLE, REQ, ERROR};
  - address width 18, word width 36;
  - octal constant PC_MAX = 18'o777777.
- One sub-module: ir_prefetch_fifo, a synchronous FIFO holding 54-bit {word, pc} entries with push, pop, flush, full, empty and count. It uses the same clk and rst, with rst asynchronous and active-low.

Test Plan:
- Reset mid-request: rst=0 while mem_req=1 -> mem_req=0, q_valid=0, ir_clken=0 immediately; after release with run=1, mem_addr=0.
- Straight-line fetch: pc_load 18'o1000, memory acks each request in 1 cycle, dec_rdy=1 -> IR loads words from 1000, 1001, 1002; ir_pc matches each; one ir_clken per word.
- Queue full: dec_rdy=0, QDEPTH=2 -> exactly 2 acks accepted, then mem_req=0; raising dec_rdy restarts fetch after one pop.
- Redirect during outstanding request: pc_load 18'o2000 in the same cycle as mem_ack for 1003 -> word discarded, queue empty, next mem_addr=2000.
- Error and timeout: mem_err with ack at 18'o777777 -> fetch_err=1, err_addr=777777, queued words still deliver. Separately, no ack for 255 cycles -> fetch_err=1. pc_load clears the flag.
- Wrap: pc_load 18'o777777 -> next request addresses 0.
